hovalaag_word_feeder: RTL

//   Host-side driver for the hovalaag core's 8-bit pin interface {data_in[5:0], rst, clk}.
//   - Takes 32-bit instruction words on a valid/ready port.
//   - Serialises each word into six 6-bit beats on data_in.
//   - Sequences the core's rst pin.
//   - Captures the core's 8-bit io_out byte a fixed delay after each word and offers it on a valid/ready port.

---
 rtl/hovalaag_word_feeder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/hovalaag_word_feeder.sv
`default_nettype none
// ============================================================================
// Module  : hovalaag_word_feeder
// Brief   : Serialises 32-bit words into 6-bit beats for the hovalaag core pins,
//           sequences the core reset and captures its io_out byte per word.
// Revision: 1.0 - initial release
// ============================================================================
module hovalaag_word_feeder #(
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned OUT_DELAY  = 2,
    parameter logic [5:0]  IDLE_BEATS = 6'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        soft_reset,
    input  logic        word_valid,
    output logic        word_ready,
    input  logic [31:0] word_data,
    output logic [5:0]  data_in,
    output logic        dut_rst,
    output logic        frame_start,
    input  logic [7:0]  dut_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        overrun
);

    localparam logic [1:0] S_RST_DUT = 2'd0;
    localparam logic [1:0] S_IDLE    = 2'd1;
    localparam logic [1:0] S_SEND    = 2'd2;

    localparam logic [3:0] c_RST_LOAD  = 4'(RST_CYCLES);
    localparam logic [2:0] c_LAST_BEAT = 3'd5;

    logic [1:0]           r_state;
    logic [3:0]           r_cnt;
    logic [2:0]           r_beat;
    logic [31:0]          r_word;
    logic [OUT_DELAY-1:0] r_mark;
    logic                 r_out_valid;
    logic [7:0]           r_out_data;
    logic                 r_overrun;

    logic                 w_accept;
    logic                 w_last_beat;
    logic                 w_cap;
    logic [3:0]           w_nib_xor;
    logic [5:0]           w_beat;

    assign w_last_beat = (r_state == S_SEND) && (r_beat == c_LAST_BEAT);
    assign word_ready  = (r_state == S_IDLE) || w_last_beat;
    assign w_accept    = word_valid && word_ready;

    always_comb begin
        w_nib_xor = 4'h0;
        for (int i = 0; i < 8; i++) begin
            w_nib_xor = w_nib_xor ^ r_word[4*i +: 4];
        end
    end

    // Beat 5 carries a nibble checksum alongside the top two word bits.
    always_comb begin
        w_beat = IDLE_BEATS;
        case (r_beat)
            3'd0:    w_beat = r_word[5:0];
            3'd1:    w_beat = r_word[11:6];
            3'd2:    w_beat = r_word[17:12];
            3'd3:    w_beat = r_word[23:18];
            3'd4:    w_beat = r_word[29:24];
            3'd5:    w_beat = {w_nib_xor, r_word[31:30]};
            default: w_beat = IDLE_BEATS;
        endcase
    end

    assign data_in     = (r_state == S_SEND) ? w_beat : IDLE_BEATS;
    assign frame_start = (r_state == S_SEND) && (r_beat == 3'd0);
    assign dut_rst     = (r_state == S_RST_DUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RST_DUT;
            r_cnt   <= c_RST_LOAD;
            r_beat  <= 3'd0;
            r_word  <= 32'h0;
        end else if (soft_reset) begin
            r_state <= S_RST_DUT;
            r_cnt   <= c_RST_LOAD;
            r_beat  <= 3'd0;
        end else begin
            case (r_state)
                S_RST_DUT: begin
                    if (r_cnt <= 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_IDLE: begin
                    if (w_accept) begin
                        r_word  <= word_data;
                        r_beat  <= 3'd0;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (r_beat == c_LAST_BEAT) begin
                        r_beat <= 3'd0;
                        if (w_accept) begin
                            r_word <= word_data;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_beat <= r_beat + 3'd1;
                    end
                end
                default: begin
                    r_state <= S_RST_DUT;
                    r_cnt   <= c_RST_LOAD;
                    r_beat  <= 3'd0;
                end
            endcase
        end
    end

    // The mark pipeline tracks beat5 timing only, so it keeps running across FSM transitions.
    assign w_cap = r_mark[OUT_DELAY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mark      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_overrun   <= 1'b0;
        end else if (soft_reset) begin
            r_mark      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_mark <= OUT_DELAY'({r_mark, w_last_beat});
            if (w_cap) begin
                r_out_data  <= dut_out;
                r_out_valid <= 1'b1;
                if (r_out_valid && !out_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire
